int_dsp_slice_mac: RTL and testbench
====================================

# int_dsp_slice_mac

Parametrised signed-integer DSP slice: next generation of the fixed 8-bit add/multiply slice used in the FPGA-fabric benchmark designs. Adds configurable operand and accumulator widths, a valid-qualified 3-stage pipeline, a saturating multiply-accumulate mode with clear and a sticky overflow flag, and an optional cascade path for building dot-product chains from adjacent slices.

## Interface
- `DWIDTH`, 8: operand width, signed two's complement.
- `ACC_WIDTH`, 24: accumulator/result width, signed; legal range 2*DWIDTH ≤ ACC_WIDTH ≤ 48.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: qualifies `ax`, `ay`, `az`, `mode`, `acc_clear` this cycle.
- `mode` in 2: 00 ADD, 01 MULT, 10 MAC, 11 MAC_CHAIN.
- `acc_clear` in 1: MAC/MAC_CHAIN only; this sample starts a new accumulation.
- `ax`, `ay`, `az` in DWIDTH each: operands.
- `chain_in` in ACC_WIDTH: cascade input (only with `DSP_SLICE_CASCADE_EN`).
- `result` out ACC_WIDTH: registered result.
- `valid_out` out 1: `result` updated this cycle.
- `overflow` out 1: sticky saturation flag.
- `chain_out` out ACC_WIDTH: equals `result` (only with `DSP_SLICE_CASCADE_EN`).

## Operation
- Stage 1 (S1): register operands, mode, acc_clear, valid; register loads only when `valid_in`=1, valid bit always loads.
- Stage 2 (S2): ADD: s = ax+ay computed at DWIDTH+1 bits, saturated to DWIDTH; MULT/MAC/MAC_CHAIN: full 2*DWIDTH signed product ay*az. Registered with valid.
- Stage 3 (S3, accumulator = `result` register), updates only when S2 valid:
  - ADD: result = sign-extend(sat_DWIDTH(ax+ay)).
  - MULT: result = sign-extend(sat_DWIDTH(ay*az)); saturation to [−2^(DWIDTH−1), 2^(DWIDTH−1)−1].
  - MAC: result = sat_ACC((acc_clear ? 0 : result) + sign-extend(product)).
  - MAC_CHAIN: result = sat_ACC(chain_in + sign-extend(product)); acc_clear ignored.
- Sums for sat_ACC computed at ACC_WIDTH+1 bits, clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- `overflow`: set on any S3 update that saturates (any mode); cleared by `reset` or an S3 MAC update with acc_clear=1 that does not itself saturate (set wins if both).
- Invalid cycles: `result`, `overflow` hold; no accumulator change. Bubbles between MAC samples allowed.
- Mode change between consecutive valid samples allowed; each sample uses its own captured mode. Switching ADD/MULT into MAC without acc_clear accumulates onto the prior `result` (defined behaviour).

## Timing
- Latency 3: sample with `valid_in`=1 in cycle n → `result`, `valid_out`=1 in cycle n+3.
- Throughput 1 sample/cycle, including back-to-back MAC (S3 feedback is single-cycle).
- `valid_out` high exactly one cycle per valid sample; order preserved.
- `chain_in` sampled at the S3 update edge (cycle n+2 for a sample in cycle n); upstream slice's `chain_out` fed directly with its valid one cycle ahead.
- Reset: `result`=0, `valid_out`=0, `overflow`=0, all pipeline valids 0; in-flight samples discarded, including a `valid_in` asserted during reset.
- First cycle after reset deassertion accepts a sample normally.

## Configuration
- `DSP_SLICE_CASCADE_EN` defined: `chain_in`/`chain_out` ports exist; mode 11 is MAC_CHAIN as above.
- Not defined: ports absent; mode 11 behaves exactly as MAC (10), including acc_clear.

## Test plan
- Reset/pipeline: reset 2 cycles, then ADD ax=5, ay=−3 at cycle 0 → cycle 3 result=2, valid_out=1; cycles 0–2 valid_out=0.
- Saturating ADD/MULT (DWIDTH=8): ADD 100+100 → 127, overflow=1; MULT −128*−128 → 127; MULT −128*127 → −128; MULT 7*−9 → −63 sign-extended.
- MAC: acc_clear with 3*4, then 2*5, bubble, −1*6 → results 12, 22, 16; valid_out three single pulses.
- Accumulator saturation (ACC_WIDTH=24): repeated MAC 127*127 → clamps at 8388607, overflow=1 sticky; next acc_clear 1*1 → result 1, overflow=0.
- Reset mid-MAC: three MAC samples in flight, reset for 1 cycle → no valid_out, result=0; subsequent MAC without acc_clear 2*2 → 4.
- Cascade (macro on): two chained slices, slice A MAC 3*3 feeding slice B MAC_CHAIN 4*4 → B result 25; macro off: mode 11 with acc_clear 2*3 then 1*1 → 6, 7.

Source files
------------

// File: rtl/int_dsp_slice_mac_if.sv
// Operand/result bundle for int_dsp_slice_mac: the producer drives the master side,
// the slice sits on the slave side. Cascade ports stay on the module itself.
interface int_dsp_slice_mac_if #(
  parameter int DWIDTH    = 8,
  parameter int ACC_WIDTH = 24
);
  logic                        valid_in;
  logic [1:0]                  mode;
  logic                        acc_clear;
  logic signed [DWIDTH-1:0]    ax;
  logic signed [DWIDTH-1:0]    ay;
  logic signed [DWIDTH-1:0]    az;
  logic signed [ACC_WIDTH-1:0] result;
  logic                        valid_out;
  logic                        overflow;

  modport master (
    output valid_in, mode, acc_clear, ax, ay, az,
    input  result, valid_out, overflow
  );

  modport slave (
    input  valid_in, mode, acc_clear, ax, ay, az,
    output result, valid_out, overflow
  );
endinterface

// File: rtl/int_dsp_slice_mac.sv
// Signed-integer DSP slice: 3-stage ADD / MULT / saturating MAC pipeline with sticky overflow.
// Define DSP_SLICE_CASCADE_EN to add chain_in/chain_out and the MAC_CHAIN mode (11).
module int_dsp_slice_mac #(
  parameter int DWIDTH    = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  int_dsp_slice_mac_if.slave          bus
`ifdef DSP_SLICE_CASCADE_EN
  ,
  input  logic signed [ACC_WIDTH-1:0] chain_in,
  output logic signed [ACC_WIDTH-1:0] chain_out
`endif
);

  localparam int PW = 2 * DWIDTH;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_MULT  = 2'b01;
  localparam logic [1:0] MODE_MAC   = 2'b10;
  localparam logic [1:0] MODE_CHAIN = 2'b11;

  localparam logic signed [DWIDTH-1:0]    DW_MAX  = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH-1:0]    DW_MIN  = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Stage 1: captured operands
  logic                        s1_valid_d, s1_valid_q;
  logic [1:0]                  s1_mode_d,  s1_mode_q;
  logic                        s1_clr_d,   s1_clr_q;
  logic signed [DWIDTH-1:0]    s1_ax_d,    s1_ax_q;
  logic signed [DWIDTH-1:0]    s1_ay_d,    s1_ay_q;
  logic signed [DWIDTH-1:0]    s1_az_d,    s1_az_q;

  // Stage 2: raw sum or full product, saturated later in stage 3
  logic                        s2_valid_d, s2_valid_q;
  logic [1:0]                  s2_mode_d,  s2_mode_q;
  logic                        s2_clr_d,   s2_clr_q;
  logic signed [PW-1:0]        s2_val_d,   s2_val_q;

  // Stage 3: accumulator / result
  logic signed [ACC_WIDTH-1:0] result_d,    result_q;
  logic                        overflow_d,  overflow_q;
  logic                        valid_out_d, valid_out_q;

  logic signed [PW-1:0]        op_sum;
  logic signed [PW-1:0]        op_prod;
  logic [DWIDTH:0]             narrow_hi;
  logic                        narrow_ovf;
  logic signed [DWIDTH-1:0]    narrow_sat;
  logic                        narrow_mode;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH:0]   acc_sum;
  logic                        acc_ovf;
  logic signed [ACC_WIDTH-1:0] acc_sat;
  logic                        acc_clear_ok;
  logic                        s3_sat;

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path can infer a latch.
    s1_valid_d = bus.valid_in;
    s1_mode_d  = s1_mode_q;
    s1_clr_d   = s1_clr_q;
    s1_ax_d    = s1_ax_q;
    s1_ay_d    = s1_ay_q;
    s1_az_d    = s1_az_q;
    if (bus.valid_in) begin
`ifdef DSP_SLICE_CASCADE_EN
      s1_mode_d = bus.mode;
`else
      // Without a cascade there is no chain operand, so mode 11 folds onto MAC here.
      s1_mode_d = (bus.mode == MODE_CHAIN) ? MODE_MAC : bus.mode;
`endif
      s1_clr_d  = bus.acc_clear;
      s1_ax_d   = bus.ax;
      s1_ay_d   = bus.ay;
      s1_az_d   = bus.az;
    end
  end

  always_comb begin
    op_sum     = PW'(s1_ax_q) + PW'(s1_ay_q);
    op_prod    = PW'(s1_ay_q) * PW'(s1_az_q);
    s2_valid_d = s1_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_clr_d   = s2_clr_q;
    s2_val_d   = s2_val_q;
    if (s1_valid_q) begin
      s2_mode_d = s1_mode_q;
      s2_clr_d  = s1_clr_q;
      s2_val_d  = (s1_mode_q == MODE_ADD) ? op_sum : op_prod;
    end
  end

  // ADD/MULT: the value fits DWIDTH only if all bits above the sign bit match it.
  always_comb begin
    narrow_hi  = s2_val_q[PW-1:DWIDTH-1];
    narrow_ovf = !((&narrow_hi) || !(|narrow_hi));
    narrow_sat = s2_val_q[DWIDTH-1:0];
    if (narrow_ovf) begin
      narrow_sat = s2_val_q[PW-1] ? DW_MIN : DW_MAX;
    end
  end

  always_comb begin
    narrow_mode  = (s2_mode_q == MODE_ADD) || (s2_mode_q == MODE_MULT);
    acc_clear_ok = (s2_mode_q == MODE_MAC) && s2_clr_q;
    acc_base     = s2_clr_q ? '0 : result_q;
`ifdef DSP_SLICE_CASCADE_EN
    if (s2_mode_q == MODE_CHAIN) begin
      acc_base = chain_in;
    end
`endif
    acc_sum = (ACC_WIDTH+1)'(acc_base) + (ACC_WIDTH+1)'(s2_val_q);
    acc_ovf = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
    acc_sat = acc_sum[ACC_WIDTH-1:0];
    if (acc_ovf) begin
      acc_sat = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    result_d    = result_q;
    overflow_d  = overflow_q;
    valid_out_d = s2_valid_q;
    s3_sat      = 1'b0;
    if (s2_valid_q) begin
      if (narrow_mode) begin
        result_d = ACC_WIDTH'(narrow_sat);
        s3_sat   = narrow_ovf;
      end else begin
        result_d = acc_sat;
        s3_sat   = acc_ovf;
      end
      // A saturating update sets the flag even when the same sample asks to clear it.
      if (s3_sat) begin
        overflow_d = 1'b1;
      end else if (acc_clear_ok) begin
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      valid_out_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      valid_out_q <= valid_out_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide when they are consumed.
  always_ff @(posedge clk) begin
    s1_mode_q <= s1_mode_d;
    s1_clr_q  <= s1_clr_d;
    s1_ax_q   <= s1_ax_d;
    s1_ay_q   <= s1_ay_d;
    s1_az_q   <= s1_az_d;
    s2_mode_q <= s2_mode_d;
    s2_clr_q  <= s2_clr_d;
    s2_val_q  <= s2_val_d;
  end

  assign bus.result    = result_q;
  assign bus.valid_out = valid_out_q;
  assign bus.overflow  = overflow_q;
`ifdef DSP_SLICE_CASCADE_EN
  assign chain_out     = result_q;
`endif

endmodule

// File: tb/tb_int_dsp_slice_mac.sv
// Directed bench for int_dsp_slice_mac (DWIDTH=8, ACC_WIDTH=24); the cascade section
// is built only when DSP_SLICE_CASCADE_EN is defined, otherwise mode 11 is checked as MAC.
module tb_int_dsp_slice_mac;

  localparam int DW = 8;
  localparam int AW = 24;

  localparam logic [1:0] M_ADD   = 2'b00;
  localparam logic [1:0] M_MULT  = 2'b01;
  localparam logic [1:0] M_MAC   = 2'b10;
  localparam logic [1:0] M_CHAIN = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  int_dsp_slice_mac_if #(.DWIDTH(DW), .ACC_WIDTH(AW)) bus ();

`ifdef DSP_SLICE_CASCADE_EN
  int_dsp_slice_mac_if #(.DWIDTH(DW), .ACC_WIDTH(AW)) bus_b ();
  logic signed [AW-1:0] chain_a_in;
  logic signed [AW-1:0] chain_a_out;
  logic signed [AW-1:0] chain_b_out;

  int_dsp_slice_mac #(.DWIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .chain_in(chain_a_in), .chain_out(chain_a_out)
  );

  int_dsp_slice_mac #(.DWIDTH(DW), .ACC_WIDTH(AW)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .chain_in(chain_a_out), .chain_out(chain_b_out)
  );
`else
  int_dsp_slice_mac #(.DWIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] m, input logic clr, input int x, input int y, input int z);
    bus.valid_in  = 1'b1;
    bus.mode      = m;
    bus.acc_clear = clr;
    bus.ax        = 8'(x);
    bus.ay        = 8'(y);
    bus.az        = 8'(z);
  endtask

  task automatic idle();
    bus.valid_in  = 1'b0;
    bus.acc_clear = 1'b0;
  endtask

  // Present one sample, then wait out the remaining two edges of its latency.
  task automatic one_sample(input logic [1:0] m, input logic clr, input int x, input int y, input int z);
    drive(m, clr, x, y, z);
    tick();
    idle();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    bus.mode = M_ADD;
    bus.ax = '0; bus.ay = '0; bus.az = '0;
`ifdef DSP_SLICE_CASCADE_EN
    chain_a_in        = '0;
    bus_b.valid_in    = 1'b0;
    bus_b.mode        = M_ADD;
    bus_b.acc_clear   = 1'b0;
    bus_b.ax = '0; bus_b.ay = '0; bus_b.az = '0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check("reset_result",    32'(bus.result),    0);
    check("reset_valid_out", 32'(bus.valid_out), 0);
    check("reset_overflow",  32'(bus.overflow),  0);

    // Latency: first cycle after reset, ADD 5 + -3 appears three edges later.
    drive(M_ADD, 1'b0, 5, -3, 0);
    tick();
    idle();
    check("lat_c1_valid_out", 32'(bus.valid_out), 0);
    tick();
    check("lat_c2_valid_out", 32'(bus.valid_out), 0);
    tick();
    check("lat_c3_valid_out", 32'(bus.valid_out), 1);
    check("add_5_m3",         32'(bus.result),    2);
    check("add_ovf_clear",    32'(bus.overflow),  0);
    tick();
    check("lat_c4_valid_out", 32'(bus.valid_out), 0);

    // Saturating ADD / MULT
    one_sample(M_ADD, 1'b0, 100, 100, 0);
    check("add_sat_result",   32'(bus.result),   127);
    check("add_sat_overflow", 32'(bus.overflow), 1);
    one_sample(M_MULT, 1'b0, 0, -128, -128);
    check("mult_m128_m128",   32'(bus.result),   127);
    one_sample(M_MULT, 1'b0, 0, -128, 127);
    check("mult_m128_127",    32'(bus.result),   -128);
    one_sample(M_MULT, 1'b0, 0, 7, -9);
    check("mult_7_m9",        32'(bus.result),   -63);
    check("mult_ovf_sticky",  32'(bus.overflow), 1);
    // MAC without clear builds on the previous MULT result.
    one_sample(M_MAC, 1'b0, 0, 2, 5);
    check("mac_onto_mult",    32'(bus.result),   -53);

    // MAC with clear, back-to-back, bubble, then one more sample.
    drive(M_MAC, 1'b1, 0, 3, 4);
    tick();
    drive(M_MAC, 1'b0, 0, 2, 5);
    tick();
    idle();
    tick();
    check("mac1_valid_out", 32'(bus.valid_out), 1);
    check("mac1_result",    32'(bus.result),    12);
    check("mac1_ovf_clear", 32'(bus.overflow),  0);
    drive(M_MAC, 1'b0, 0, -1, 6);
    tick();
    idle();
    check("mac2_valid_out", 32'(bus.valid_out), 1);
    check("mac2_result",    32'(bus.result),    22);
    tick();
    check("bubble_valid_out", 32'(bus.valid_out), 0);
    check("bubble_hold",      32'(bus.result),    22);
    tick();
    check("mac3_valid_out", 32'(bus.valid_out), 1);
    check("mac3_result",    32'(bus.result),    16);

    // Accumulator saturation: 520 * 16129 = 8387080 fits, the 521st sample clamps.
    for (int i = 0; i < 520; i++) begin
      drive(M_MAC, (i == 0), 0, 127, 127);
      tick();
    end
    idle();
    tick();
    tick();
    check("acc_near_max", 32'(bus.result),   8387080);
    check("acc_near_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 3; i++) begin
      drive(M_MAC, 1'b0, 0, 127, 127);
      tick();
    end
    idle();
    tick();
    tick();
    check("acc_clamp_max", 32'(bus.result),   8388607);
    check("acc_clamp_ovf", 32'(bus.overflow), 1);
    one_sample(M_MAC, 1'b1, 0, 1, 1);
    check("acc_clear_result", 32'(bus.result),   1);
    check("acc_clear_ovf",    32'(bus.overflow), 0);

    // Reset with samples in flight, including a sample presented during reset.
    drive(M_MAC, 1'b1, 0, 5, 5);
    tick();
    drive(M_MAC, 1'b0, 0, 6, 6);
    tick();
    drive(M_MAC, 1'b0, 0, 7, 7);
    tick();
    reset = 1'b1;
    drive(M_MAC, 1'b0, 0, 9, 9);
    tick();
    reset = 1'b0;
    check("rst_mid_result",    32'(bus.result),    0);
    check("rst_mid_valid_out", 32'(bus.valid_out), 0);
    drive(M_MAC, 1'b0, 0, 2, 2);
    tick();
    idle();
    check("rst_drain1_valid_out", 32'(bus.valid_out), 0);
    check("rst_drain1_result",    32'(bus.result),    0);
    tick();
    check("rst_drain2_valid_out", 32'(bus.valid_out), 0);
    tick();
    check("post_rst_valid_out", 32'(bus.valid_out), 1);
    check("post_rst_mac",       32'(bus.result),    4);

`ifdef DSP_SLICE_CASCADE_EN
    // Slice A MAC 3*3 feeds slice B MAC_CHAIN 4*4 issued one cycle later.
    drive(M_MAC, 1'b1, 0, 3, 3);
    tick();
    idle();
    bus_b.valid_in  = 1'b1;
    bus_b.mode      = M_CHAIN;
    bus_b.acc_clear = 1'b0;
    bus_b.ay        = 8'(4);
    bus_b.az        = 8'(4);
    tick();
    bus_b.valid_in  = 1'b0;
    tick();
    check("chain_a_result", 32'(bus.result), 9);
    tick();
    check("chain_b_valid_out", 32'(bus_b.valid_out), 1);
    check("chain_b_result",    32'(bus_b.result),    25);
    check("chain_out_mirror",  32'(chain_b_out),     25);
`else
    // Mode 11 without the cascade behaves exactly as MAC, including acc_clear.
    drive(M_CHAIN, 1'b1, 0, 2, 3);
    tick();
    drive(M_CHAIN, 1'b0, 0, 1, 1);
    tick();
    idle();
    tick();
    check("m11_first_result", 32'(bus.result), 6);
    tick();
    check("m11_second_valid", 32'(bus.valid_out), 1);
    check("m11_second_result", 32'(bus.result), 7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
